// File: rtl/report_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : report_tx_arbiter
//  Description : Round-robin scheduler that shares one byte-stream
//                transmitter among up to 16 report sources. A granted
//                report is framed as SYNC, ID, payload (MSB first) and
//                CHK bytes, then streamed out over a valid/ready handshake.
//
//  Ports
//    clk          : single clock, rising edge
//    reset        : asynchronous, active-high reset
//    req_valid    : [N_REQ]        requester i has a report pending
//    req_data     : [N_REQ*DATA_W] report of requester i at [i*DATA_W +: DATA_W]
//    req_ready    : [N_REQ]        one-hot accept, only asserted while idle
//    tx_data      : [8]            current frame byte (registered)
//    tx_valid     : 1              tx_data is valid (registered)
//    tx_ready     : 1              transmitter accepts tx_data this cycle
//    busy         : 1              a frame is in progress
//    grant_id     : [4]            owner of the current / most recent frame
//    frames_sent  : [16]           completed frame count, wraps at 0xFFFF
//
//  Revision    : 1.0  initial release
// ============================================================================
module report_tx_arbiter #(
    parameter int          N_REQ     = 4,
    parameter int          DATA_W    = 32,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      busy,
    output logic [3:0]                grant_id,
    output logic [15:0]               frames_sent
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int         c_N_BYTES   = DATA_W / 8;
    localparam logic [3:0] c_LAST_BYTE = 4'(c_N_BYTES - 1);
    // Pointer starts at the top index so requester 0 wins first.
    localparam logic [3:0] c_RR_RESET  = 4'(N_REQ - 1);

    // ------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_ID   = 3'd2,
        S_DATA = 3'd3,
        S_CHK  = 3'd4
    } state_t;

    state_t              r_state;
    logic [7:0]          r_tx_data;
    logic                r_tx_valid;
    logic [DATA_W-1:0]   r_payload;
    logic [3:0]          r_byte_cnt;
    logic [7:0]          r_chk_acc;
    logic [3:0]          r_grant_id;
    logic [3:0]          r_rr_ptr;
    logic [15:0]         r_frames_sent;

    logic                w_any;
    logic [3:0]          w_sel;
    logic [DATA_W-1:0]   w_sel_data;
    logic [4:0]          w_best;
    logic [4:0]          w_dist;
    logic                w_accept;

    // ------------------------------------------------------------------
    // Round-robin selection
    // Each valid requester gets a distance from the slot after the last
    // grant (0 = highest priority). The smallest distance wins, which is
    // the same as scanning upward from rr_ptr+1 with wrap-around, but
    // needs no variable indexing.
    // ------------------------------------------------------------------
    always_comb begin
        w_any      = 1'b0;
        w_sel      = '0;
        w_sel_data = '0;
        w_best     = 5'd31;
        w_dist     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_dist = 5'((i + 2 * N_REQ - 1 - int'(r_rr_ptr)) % N_REQ);
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best     = w_dist;
                w_sel      = 4'(i);
                w_sel_data = req_data[i*DATA_W +: DATA_W];
                w_any      = 1'b1;
            end
        end
    end

    // Ready is combinational so the grant completes in the same cycle the
    // arbiter decides; it can only be high while idle.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = (r_state == S_IDLE) && w_any && (w_sel == 4'(i));
        end
    end

    // A byte moves only when the registered valid meets ready; ready on
    // its own has no effect.
    assign w_accept = r_tx_valid && tx_ready;

    // ------------------------------------------------------------------
    // Frame sequencer
    // tx_data always holds the byte on offer; on acceptance it is
    // replaced by the next one, so the output stays stable under
    // backpressure. The payload register shifts left so its top byte is
    // always the next payload byte to send.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_tx_data     <= 8'h00;
            r_tx_valid    <= 1'b0;
            r_payload     <= '0;
            r_byte_cnt    <= 4'd0;
            r_chk_acc     <= 8'h00;
            r_grant_id    <= 4'd0;
            r_rr_ptr      <= c_RR_RESET;
            r_frames_sent <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_payload  <= w_sel_data;
                        r_grant_id <= w_sel;
                        r_rr_ptr   <= w_sel;
                        r_chk_acc  <= 8'h00;
                        r_byte_cnt <= 4'd0;
                        r_tx_data  <= SYNC_BYTE;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_SYNC;
                    end
                end

                S_SYNC: begin
                    if (w_accept) begin
                        r_tx_data <= {4'h0, r_grant_id};
                        r_state   <= S_ID;
                    end
                end

                S_ID: begin
                    if (w_accept) begin
                        r_chk_acc  <= r_chk_acc + r_tx_data;
                        r_tx_data  <= r_payload[DATA_W-1 -: 8];
                        r_payload  <= r_payload << 8;
                        r_byte_cnt <= 4'd0;
                        r_state    <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (w_accept) begin
                        r_chk_acc <= r_chk_acc + r_tx_data;
                        if (r_byte_cnt == c_LAST_BYTE) begin
                            // The accumulator does not yet include the byte
                            // being accepted now, so fold it in directly.
                            r_tx_data <= r_chk_acc + r_tx_data;
                            r_state   <= S_CHK;
                        end else begin
                            r_tx_data  <= r_payload[DATA_W-1 -: 8];
                            r_payload  <= r_payload << 8;
                            r_byte_cnt <= r_byte_cnt + 4'd1;
                        end
                    end
                end

                S_CHK: begin
                    if (w_accept) begin
                        r_tx_valid    <= 1'b0;
                        r_frames_sent <= r_frames_sent + 16'd1;
                        r_state       <= S_IDLE;
                    end
                end

                default: begin
                    r_tx_valid <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign busy        = (r_state != S_IDLE);
    assign grant_id    = r_grant_id;
    assign frames_sent = r_frames_sent;

endmodule
`default_nettype wire

// File: tb/tb_report_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_report_tx_arbiter
//  Description : Self-checking bench for report_tx_arbiter. A byte-queue
//                reference model predicts grants and the exact transmitted
//                byte stream; directed scenarios plus a randomized phase.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_report_tx_arbiter;

    localparam int c_N  = 4;
    localparam int c_DW = 32;

    logic                 clk;
    logic                 reset;
    logic [c_N-1:0]       req_valid;
    logic [c_N*c_DW-1:0]  req_data;
    logic [c_N-1:0]       req_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 busy;
    logic [3:0]           grant_id;
    logic [15:0]          frames_sent;

    report_tx_arbiter #(
        .N_REQ     (c_N),
        .DATA_W    (c_DW),
        .SYNC_BYTE (8'hA5)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .grant_id    (grant_id),
        .frames_sent (frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus applied at the next cycle
    logic [c_N-1:0]       d_valid;
    logic [c_N*c_DW-1:0]  d_data;
    logic                 d_ready;

    // Reference model
    logic [7:0] m_q[$];      // bytes still to be sent for the current frame
    int         m_last;      // last granted index (round-robin origin)
    int         m_gid;       // expected grant_id
    int         m_frames;    // completed frames

    // Observation logs
    logic [7:0] blog[$];     // bytes actually accepted from the DUT
    int         glog[$];     // requesters actually granted by the DUT

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic int exp_grant();
        for (int k = 1; k <= c_N; k++) begin
            int idx;
            idx = (m_last + k) % c_N;
            if (d_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic push_frame(input int g, input logic [31:0] w);
        int sum;
        m_q.push_back(8'hA5);
        m_q.push_back(8'(g));
        sum = g;
        for (int b = 3; b >= 0; b--) begin
            int v;
            v = int'((w >> (8 * b)) & 32'hFF);
            m_q.push_back(8'(v));
            sum += v;
        end
        m_q.push_back(8'(sum % 256));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last   = c_N - 1;
        m_gid    = 0;
        m_frames = 0;
    endtask

    // One clock: drive at the falling edge, sample 1 time unit later, and
    // predict what the next rising edge will do.
    task automatic step();
        int g;
        @(negedge clk);
        req_valid = d_valid;
        req_data  = d_data;
        tx_ready  = d_ready;
        #1;
        check("busy", busy, 32'(m_q.size() != 0));
        check("tx_valid", tx_valid, 32'(m_q.size() != 0));
        if (m_q.size() != 0) check("tx_data", tx_data, m_q[0]);
        check("frames_sent", frames_sent, 32'(m_frames % 65536));
        check("grant_id", grant_id, m_gid);
        for (int k = 0; k < c_N; k++)
            if (req_ready[k] && req_valid[k]) glog.push_back(k);
        if (m_q.size() == 0) begin
            g = exp_grant();
            check("req_ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
            if (g >= 0) begin
                push_frame(g, d_data[g*c_DW +: c_DW]);
                m_last = g;
                m_gid  = g;
            end
        end else begin
            check("req_ready_busy", req_ready, 32'd0);
            if (d_ready) begin
                blog.push_back(tx_data);
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_frames++;
            end
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #1;
        d_valid   = '0;
        req_valid = '0;
        reset     = 1'b1;
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_frames", frames_sent, 0);
        check("rst_req_ready", req_ready, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (m_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (m_q.size() != 0) check("timeout_idle", 1, 0);
    endtask

    task automatic wait_grant(input int budget);
        int n;
        n = 0;
        while (m_q.size() == 0 && n < budget) begin
            step();
            n++;
        end
        if (m_q.size() == 0) check("timeout_grant", 1, 0);
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] e[7]);
        check({tag, "_len"}, blog.size(), 7);
        for (int k = 0; k < 7; k++)
            if (k < blog.size()) check($sformatf("%s_b%0d", tag, k), blog[k], e[k]);
    endtask

    logic [7:0] e_single[7];
    logic [7:0] e_wrap[7];
    int         e_order[5];

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        d_valid   = '0;
        d_data    = '0;
        d_ready   = 1'b0;
        model_reset();
        e_single = '{8'hA5, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
        e_wrap   = '{8'hA5, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        e_order  = '{0, 1, 2, 3, 0};

        reset_dut();

        // Single report from requester 0
        blog.delete(); glog.delete();
        d_valid = 4'b0001;
        d_data  = '0;
        d_data[31:0] = 32'h1122_3344;
        d_ready = 1'b1;
        step();
        d_valid = '0;
        wait_idle(20);
        step();
        check_bytes("single", e_single);
        check("single_grants", glog.size(), 1);
        check("single_frames", frames_sent, 1);

        // Fairness from reset: all requesters valid
        reset_dut();
        glog.delete();
        d_valid = 4'hF;
        d_ready = 1'b1;
        for (int n = 0; n < 80 && m_frames < 5; n++) step();
        check("fair_frames", 32'(m_frames >= 5), 1);
        d_valid = '0;
        wait_idle(20);
        check("fair_len", 32'(glog.size() >= 5), 1);
        for (int k = 0; k < 5; k++)
            if (k < glog.size()) check($sformatf("fair_g%0d", k), glog[k], e_order[k]);

        // Checksum wrap from requester 3
        blog.delete();
        d_data = {$urandom, $urandom, $urandom, $urandom};
        d_data[3*c_DW +: c_DW] = 32'hFFFF_FFFF;
        d_valid = 4'b1000;
        wait_grant(10);
        d_valid = '0;
        d_data  = {$urandom, $urandom, $urandom, $urandom};
        wait_idle(20);
        check_bytes("wrap", e_wrap);

        // Backpressure then reset in the middle of a frame from requester 1
        d_valid = 4'b0010;
        d_data  = {$urandom, $urandom, $urandom, $urandom};
        for (int n = 0; n < 200 && m_q.size() != 4; n++) begin
            d_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        check("midrst_reached", m_q.size(), 4);
        reset_dut();
        check("midrst_valid", tx_valid, 0);
        blog.delete();
        d_valid = 4'b0010;
        d_data  = {$urandom, $urandom, $urandom, $urandom};
        wait_grant(10);
        d_valid = '0;
        for (int n = 0; n < 200 && m_q.size() != 0; n++) begin
            d_ready = $urandom_range(0, 1);
            d_data  = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        check("post_len", blog.size(), 7);
        if (blog.size() >= 2) begin
            check("post_sync", blog[0], 8'hA5);
            check("post_id", blog[1], 8'h01);
        end

        // Randomized traffic with backpressure and fickle requesters
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) == 0) d_valid = 4'($urandom_range(0, 15));
            d_data  = {$urandom, $urandom, $urandom, $urandom};
            d_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        d_valid = '0;
        d_ready = 1'b1;
        wait_idle(20);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/report_tx_arbiter.md
# report_tx_arbiter

Round-robin scheduler that shares one byte-stream transmitter (the UART TX or SPI-slave MISO path) among up to 16 vision-side report sources, such as per-colour blob detectors in the image-processing pipeline. It accepts one fixed-width report at a time from a requester and frames it as sync, ID, payload and checksum bytes. It then drives those bytes out over a valid/ready handshake to the serialiser. It sits between the image-processing result registers and the transmitter in the Qsys system.

## Interface
Parameters:
- N_REQ, 4, number of requesters; legal range 1..16.
- DATA_W, 32, report payload width in bits; must be a multiple of 8, legal range 8..64.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  single clock; every register is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  requester i has a report pending.
- req_data  in  N_REQ*DATA_W  report of requester i, in bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  one-hot; a report is accepted when req_valid[i] and req_ready[i] are both high at a clock edge.
- tx_data  out  8  current frame byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts tx_data this cycle.
- busy  out  1  a frame is in progress (state is not IDLE).
- grant_id  out  4  index of the requester that owns the current or most recent frame.
- frames_sent  out  16  count of completed frames; wraps from 0xFFFF to 0.

## Operation
- Frame format: SYNC_BYTE, ID, then DATA_W/8 payload bytes MSB first, then CHK.
  - ID = grant index, zero-extended to 8 bits.
  - CHK = (ID + all payload bytes) mod 256. SYNC_BYTE is not included.
  - Frame length L = 3 + DATA_W/8 (7 bytes by default).
- States: IDLE, SYNC, ID, DATA, CHK.
- IDLE:
  - If any req_valid bit is high, select the first valid requester searching from rr_ptr+1 upward, modulo N_REQ.
  - req_ready for that requester is high combinationally in the same cycle. All other req_ready bits stay low.
  - At the clock edge: capture req_data into the payload shift register, set grant_id and rr_ptr to the granted index, clear the checksum accumulator, and go to SYNC.
- SYNC → ID → DATA → CHK: each state advances only on a cycle where tx_valid and tx_ready are both high.
  - DATA uses a byte counter running 0..DATA_W/8-1. It leaves DATA after the last payload byte is accepted.
  - The accumulator adds each byte as it is accepted in ID and DATA.
- CHK accepted: increment frames_sent and return to IDLE.
- Requester rules:
  - A requester may drop req_valid before being granted. Nothing is captured in that case.
  - req_data is sampled only at the grant edge. Changes after the grant have no effect on the frame.
- tx_ready while tx_valid is low is ignored.
- reset (asynchronous):
  - State goes to IDLE, tx_valid=0, tx_data=0, req_ready=0, busy=0, grant_id=0, frames_sent=0, rr_ptr=N_REQ-1 (requester 0 has first priority).
  - Reset mid-frame aborts the frame with no completion. The receiver resynchronises on the next SYNC_BYTE.

## Timing
- Grant to first byte: tx_valid rises with SYNC_BYTE one cycle after the grant edge.
- tx_data and tx_valid are registered. They are held stable while tx_valid=1 and tx_ready=0.
- With tx_ready held at 1:
  - L consecutive byte cycles per frame.
  - One IDLE cycle between frames.
  - Sustained throughput is one frame per L+1 cycles.
- busy is high from the cycle after the grant until the cycle CHK is accepted, inclusive.
- frames_sent updates on the edge that accepts CHK.
- Only one req_ready bit can ever be high, and only while in IDLE.

## Test plan
- Single report: req_valid=4'b0001 with data0=0x11223344, tx_ready=1 → req_ready[0] pulses for 1 cycle; bytes A5 00 11 22 33 44 AA appear on consecutive cycles; frames_sent=1.
- Fairness: all four requesters held valid for 5 frames → grant order 0,1,2,3,0 with one IDLE cycle between frames.
- Backpressure: tx_ready toggling pseudo-randomly during a frame → each byte is held stable until accepted; no byte is lost or duplicated; byte order is unchanged.
- Checksum wrap: requester 3 sends 0xFFFFFFFF → bytes A5 03 FF FF FF FF FF; the 0xFF checksum is (0x03+0x3FC) mod 256.
- Reset mid-frame: assert reset during the DATA state of requester 1 → tx_valid drops immediately and frames_sent=0. After release, a new request from requester 1 yields a full frame starting with A5 01.
- Counter wrap: force 65536 frames (or 2 frames after preloading 0xFFFE in a sim-only variant) → frames_sent reads 0x0000 after the last frame.
